// File: rtl/dmem_responder_if.sv
// Core data-port bundle between the core (master) and the data-memory responder (slave).
// Signal names are taken from the responder's side of the link.
interface dmem_responder_if #(
   parameter int XLEN = 32
);
   logic              i_storeReq;
   logic              i_loadReq;
   logic [XLEN-1:0]   i_dataAddr;
   logic [XLEN-1:0]   i_dataIn;
   logic [XLEN/8-1:0] i_byteEn;
   logic              o_memValid;
   logic [XLEN-1:0]   o_dataOut;
   logic              o_addrErr;

   modport master (
      output i_storeReq, i_loadReq, i_dataAddr, i_dataIn, i_byteEn,
      input  o_memValid, o_dataOut, o_addrErr
   );

   modport slave (
      input  i_storeReq, i_loadReq, i_dataAddr, i_dataIn, i_byteEn,
      output o_memValid, o_dataOut, o_addrErr
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM answering core loads after LOAD_LATENCY cycles (1-cycle o_memValid pulse).
// Stores are never back-pressured; a load is held by the core until o_memValid, dropping it in WAIT aborts.
module dmem_responder #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 1024,
   parameter int LOAD_LATENCY = 2,
   parameter     INIT_FILE    = ""
) (
   input  logic            i_clk,
   input  logic            i_rst,
   dmem_responder_if.slave bus
);
   localparam int         AW       = $clog2(DEPTH);
   localparam int         NB       = XLEN / 8;
   localparam logic [3:0] CNT_INIT = (LOAD_LATENCY >= 2) ? 4'(LOAD_LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic [AW-1:0]   word_q;
   logic            oor_q;
   logic [XLEN-1:0] mem [DEPTH];

   logic [AW-1:0]   addr_word;
   logic            addr_oor;
   logic            st_en;
   logic [AW-1:0]   rd_word;
   logic            rd_oor;
   logic [XLEN-1:0] rd_data;
   logic            resp_go;
   logic            unused_addr_lsb;

   assign addr_word       = bus.i_dataAddr[AW+1:2];
   assign addr_oor        = |bus.i_dataAddr[XLEN-1:AW+2];
   assign st_en           = bus.i_storeReq & ~addr_oor;
   assign unused_addr_lsb = ^bus.i_dataAddr[1:0];

   always_ff @(posedge i_clk) begin
      if (st_en) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.i_byteEn[b]) mem[addr_word][8*b +: 8] <= bus.i_dataIn[8*b +: 8];
         end
      end
   end

   // Read port merges a same-edge store so the response sees the new word (write-first).
   always_comb begin
      rd_word = (state == S_IDLE) ? addr_word : word_q;
      rd_oor  = (state == S_IDLE) ? addr_oor  : oor_q;
      rd_data = mem[rd_word];
      if (st_en && (addr_word == rd_word)) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.i_byteEn[b]) rd_data[8*b +: 8] = bus.i_dataIn[8*b +: 8];
         end
      end
      resp_go = 1'b0;
      if (bus.i_loadReq) begin
         if ((state == S_IDLE) && (LOAD_LATENCY == 1)) resp_go = 1'b1;
         if ((state == S_WAIT) && (cnt == 4'd0))       resp_go = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state          <= S_IDLE;
         cnt            <= 4'd0;
         word_q         <= '0;
         oor_q          <= 1'b0;
         bus.o_memValid <= 1'b0;
         bus.o_dataOut  <= '0;
         bus.o_addrErr  <= 1'b0;
      end else begin
         bus.o_memValid <= 1'b0;
         bus.o_addrErr  <= bus.i_storeReq & addr_oor;
         if (resp_go) begin
            bus.o_memValid <= 1'b1;
            bus.o_dataOut  <= rd_oor ? '0 : rd_data;
            if (rd_oor) bus.o_addrErr <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (bus.i_loadReq) begin
                  word_q <= addr_word;
                  oor_q  <= addr_oor;
                  cnt    <= CNT_INIT;
                  state  <= (LOAD_LATENCY == 1) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!bus.i_loadReq)  state <= S_IDLE;
               else if (cnt == 4'd0) state <= S_RESP;
               else                  cnt   <= cnt - 4'd1;
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LOAD_LATENCY 1,2,3) share one core-side stimulus bus.
module tb_dmem_responder;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        store_req = 1'b0;
   logic        load_req = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] din = '0;
   logic [3:0]  ben = '0;

   logic        vld  [1:3];
   logic [31:0] dout [1:3];
   logic        err  [1:3];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 i_clk = ~i_clk;

   for (genvar g = 1; g <= 3; g++) begin : g_dut
      dmem_responder_if #(.XLEN(32)) u_if ();
      assign u_if.i_storeReq = store_req;
      assign u_if.i_loadReq  = load_req;
      assign u_if.i_dataAddr = addr;
      assign u_if.i_dataIn   = din;
      assign u_if.i_byteEn   = ben;
      assign vld[g]  = u_if.o_memValid;
      assign dout[g] = u_if.o_dataOut;
      assign err[g]  = u_if.o_addrErr;
      dmem_responder #(
         .XLEN(32), .DEPTH(1024), .LOAD_LATENCY(g), .INIT_FILE("")
      ) u_dut (
         .i_clk(i_clk),
         .i_rst(i_rst),
         .bus  (u_if)
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge i_clk);
   endtask

   // Single store; the error flag of the L=2 responder is checked one cycle later.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic exp_err);
      @(negedge i_clk);
      store_req = 1'b1; addr = a; din = d; ben = be;
      @(negedge i_clk);
      store_req = 1'b0; ben = '0;
      chk("store_err", 32'(err[2]), 32'(exp_err));
   endtask

   // Load through responder s; checks latency, data, error flag and absence of a second pulse.
   task automatic do_load(input int s, input logic [31:0] a, input logic [31:0] exp_d,
                          input logic exp_err);
      int lat;
      int extra;
      lat = 0;
      extra = 0;
      @(negedge i_clk);
      load_req = 1'b1; addr = a;
      for (int k = 1; k <= 20; k++) begin
         @(negedge i_clk);
         if (vld[s]) begin lat = k; break; end
      end
      chk($sformatf("lat_L%0d", s), 32'(lat), 32'(s));
      chk($sformatf("data_L%0d", s), dout[s], exp_d);
      chk($sformatf("err_L%0d", s), 32'(err[s]), 32'(exp_err));
      load_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge i_clk);
         if (vld[s]) extra++;
      end
      chk($sformatf("extra_L%0d", s), 32'(extra), 32'd0);
   endtask

   initial begin
      int t1;
      int t2;
      @(negedge i_clk);
      chk("rst_vld", 32'(vld[2]), 32'd0);
      chk("rst_dout", dout[2], 32'd0);
      chk("rst_err", 32'(err[2]), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      idle(2);

      // Byte-lane merge, seen at every latency.
      do_store(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      do_store(32'h10, 32'h0000_5500, 4'b0010, 1'b0);
      do_load(2, 32'h10, 32'hDEAD55EF, 1'b0);
      do_load(1, 32'h10, 32'hDEAD55EF, 1'b0);
      do_load(3, 32'h10, 32'hDEAD55EF, 1'b0);

      // Reset in the middle of a WAIT aborts the load.
      @(negedge i_clk);
      load_req = 1'b1; addr = 32'h10;
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      chk("midrst_vld", 32'(vld[3]), 32'd0);
      chk("midrst_dout", dout[3], 32'd0);
      chk("midrst_err", 32'(err[3]), 32'd0);
      load_req = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;
      t1 = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge i_clk);
         if (vld[1] || vld[2] || vld[3]) t1++;
      end
      chk("midrst_nopulse", 32'(t1), 32'd0);

      // Back-to-back loads with loadReq held high.
      do_store(32'h0, 32'h1111_1111, 4'hF, 1'b0);
      do_store(32'h4, 32'h2222_2222, 4'hF, 1'b0);
      idle(2);
      @(negedge i_clk);
      load_req = 1'b1; addr = 32'h0;
      t1 = 0; t2 = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge i_clk);
         if (vld[3]) begin t1 = k; break; end
      end
      chk("b2b_data0", dout[3], 32'h1111_1111);
      addr = 32'h4;
      for (int k = 1; k <= 20; k++) begin
         @(negedge i_clk);
         if (vld[3]) begin t2 = k; break; end
      end
      chk("b2b_lat0", 32'(t1), 32'd3);
      chk("b2b_gap", 32'(t2), 32'd4);
      chk("b2b_data1", dout[3], 32'h2222_2222);
      load_req = 1'b0;
      idle(6);

      // Store lands on the edge that samples load data: write-first.
      do_store(32'h8, 32'hAAAA_AAAA, 4'hF, 1'b0);
      idle(2);
      @(negedge i_clk);
      load_req = 1'b1; addr = 32'h8;
      @(negedge i_clk);
      @(negedge i_clk);
      store_req = 1'b1; din = 32'h1234_5678; ben = 4'hF;
      @(negedge i_clk);
      store_req = 1'b0; ben = '0;
      chk("wf_vld", 32'(vld[3]), 32'd1);
      chk("wf_data", dout[3], 32'h1234_5678);
      load_req = 1'b0;
      idle(6);
      do_load(2, 32'h8, 32'h1234_5678, 1'b0);

      // Out-of-range accesses.
      do_load(2, 32'h1000, 32'h0, 1'b1);
      do_store(32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1);
      idle(2);
      do_load(2, 32'h0, 32'h1111_1111, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
